// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: default widths and channel limits shared by tick_gen and its testbench.
package tick_gen_pkg;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_SCAN_W = 2;
  localparam int MAX_CH     = 16;
endpackage

// File: rtl/tick_gen_if.sv
// tick_gen_if: control inputs and tick/phase outputs of tick_gen.
// scan_idx and its width parameter exist only when TICK_GEN_SCAN_EN is defined.
interface tick_gen_if import tick_gen_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
`ifdef TICK_GEN_SCAN_EN
  , parameter int SCAN_W = DEF_SCAN_W
`endif
);
  logic [NUM_CH*CNT_W-1:0] div_val;
  logic [NUM_CH-1:0]       ch_en;
  logic                    sync_clr;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       phase;
`ifdef TICK_GEN_SCAN_EN
  logic [SCAN_W-1:0]       scan_idx;

  modport master (output div_val, ch_en, sync_clr, input tick, phase, scan_idx);
  modport slave  (input div_val, ch_en, sync_clr, output tick, phase, scan_idx);
`else
  modport master (output div_val, ch_en, sync_clr, input tick, phase);
  modport slave  (input div_val, ch_en, sync_clr, output tick, phase);
`endif
endinterface

// File: rtl/tick_chan.sv
// tick_chan: one divider channel -- counter, >= compare, registered tick pulse and phase toggle.
module tick_chan import tick_gen_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_tick,
  output logic             o_phase
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_phase;
  logic             w_hit;

  // >= (not ==) so a divide value lowered below the running count ends the
  // period on the next enabled edge instead of wrapping through 2^CNT_W.
  assign w_hit = (r_cnt >= i_div);

  // Count while enabled; terminal count restarts at 0, pulses tick, flips phase.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_phase <= 1'b0;
    end else if (i_en) begin
      if (w_hit) begin
        r_cnt   <= '0;
        r_tick  <= 1'b1;
        r_phase <= ~r_phase;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_tick  = r_tick;
  assign o_phase = r_phase;
endmodule

// File: rtl/tick_gen.sv
// tick_gen: NUM_CH independent programmable tick/phase generators.
// Optional macro TICK_GEN_SCAN_EN adds scan_idx, advanced once per tick[SCAN_CH].
module tick_gen import tick_gen_pkg::*; #(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int SCAN_W  = DEF_SCAN_W,
  parameter int SCAN_CH = 0
) (
  input logic       clk,
  input logic       rst,
  tick_gen_if.slave bus
);
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_phase;

  // Reject configurations the channel indexing cannot support.
  if (NUM_CH < 1 || NUM_CH > MAX_CH || SCAN_CH < 0 || SCAN_CH >= NUM_CH || SCAN_W < 1)
  begin : g_cfg_err
    $error("tick_gen: illegal NUM_CH/SCAN_CH/SCAN_W");
  end

  // One channel per tick output; each takes its own slice of div_val.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_chan #(.CNT_W(CNT_W)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (bus.sync_clr),
      .i_en    (bus.ch_en[g]),
      .i_div   (bus.div_val[g*CNT_W +: CNT_W]),
      .o_tick  (w_tick[g]),
      .o_phase (w_phase[g])
    );
  end

  assign bus.tick  = w_tick;
  assign bus.phase = w_phase;

`ifdef TICK_GEN_SCAN_EN
  logic [SCAN_W-1:0] r_scan_idx;

  // Advance the display index the cycle after the selected channel ticks.
  always_ff @(posedge clk) begin
    if (rst || bus.sync_clr) r_scan_idx <= '0;
    else if (w_tick[SCAN_CH]) r_scan_idx <= r_scan_idx + 1'b1;
  end

  assign bus.scan_idx = r_scan_idx;
`endif
endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent tick channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: width of each channel counter and divide value.
REQ-003 SHALL have parameter SCAN_W, default 2: width of scan index (only used with TICK_GEN_SCAN_EN).
REQ-004 SHALL have parameter SCAN_CH, default 0: channel whose tick advances the scan index.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port div_val, input, NUM_CH*CNT_W bits: channel i terminal count in bits [i*CNT_W +: CNT_W].
REQ-008 SHALL have port ch_en, input, NUM_CH bits: per-channel count enable.
REQ-009 SHALL have port sync_clr, input, 1 bit: clears all channel state in one cycle.
REQ-010 SHALL have port tick, output, NUM_CH bits: registered one-cycle pulse per channel period.
REQ-011 SHALL have port phase, output, NUM_CH bits: registered square wave, toggled on each tick of that channel.
REQ-012 SHALL have port scan_idx, output, SCAN_W bits, present only when TICK_GEN_SCAN_EN is defined.

Function
REQ-013 SHALL hold one CNT_W-bit counter cnt[i] per channel, all channels independent.
REQ-014 SHALL, when ch_en[i]=1 and cnt[i] >= div[i], set cnt[i]<=0, tick[i]<=1, phase[i]<=~phase[i].
REQ-015 SHALL, when ch_en[i]=1 and cnt[i] < div[i], set cnt[i]<=cnt[i]+1, tick[i]<=0, phase[i] held.
REQ-016 SHALL, when ch_en[i]=0, hold cnt[i] and phase[i] and drive tick[i]<=0.
REQ-017 SHALL give tick period div[i]+1 cycles and phase period 2*(div[i]+1) cycles (50 % duty).
REQ-018 SHALL, with cnt=0 and ch_en[i] high from edge 1, assert tick[i] in the cycle after edge div[i]+1.
REQ-019 SHALL treat div[i]=0 as tick every enabled cycle, phase toggling every enabled cycle.
REQ-020 SHALL use >= compare so a div[i] lowered below cnt[i] mid-count ticks on the next enabled edge, never wraps through 2^CNT_W.
REQ-021 SHALL never overflow cnt[i]; cnt[i] = 2^CNT_W-1 with div[i] = 2^CNT_W-1 ticks and returns to 0.
REQ-022 SHALL apply sync_clr with priority over ch_en: all cnt, tick, phase <=0 (and scan_idx<=0 if present).
REQ-023 SHALL sample div_val every cycle; no latching or handshake required.

Reset
REQ-024 SHALL, on rst=1 at a clk edge, set every cnt, tick, phase to 0 and scan_idx to 0; rst overrides sync_clr and ch_en.
REQ-025 SHALL resume counting from 0 on the first edge after rst deasserts if ch_en is high; mid-period reset discards partial count.

Configuration
REQ-026 SHALL, with macro TICK_GEN_SCAN_EN defined, add scan_idx: increments by 1 (mod 2^SCAN_W) in the cycle after each tick[SCAN_CH], for display multiplexing.
REQ-027 SHALL, without TICK_GEN_SCAN_EN, omit scan_idx port and its register entirely; tick/phase behaviour is identical.

Structure
REQ-028 SHALL place default widths (CNT_W=32, SCAN_W=2, NUM_CH=4) and the max-channel constant in package tick_gen_pkg.
REQ-029 SHALL implement one channel (counter, compare, tick, phase) as sub-module tick_chan, instantiated NUM_CH times by generate.

Verification
REQ-030 SHALL check: rst, then ch_en=4'b0001, div0=4 -> tick[0] high at cycles 5,10,15; phase[0] toggles at same cycles; other ticks 0.
REQ-031 SHALL check: div1=0, ch_en[1]=1 -> tick[1] high every cycle, phase[1] alternates 0,1,0,1.
REQ-032 SHALL check: div2=9, cnt2 reaches 7, div2 changed to 3 -> tick[2] on next edge, then every 4 cycles.
REQ-033 SHALL check: ch_en[0] dropped for 3 cycles at cnt0=2 (div0=4) -> no tick, cnt held; tick resumes 2 enabled cycles + 1 later.
REQ-034 SHALL check: sync_clr and ch_en both high mid-period -> all tick/phase 0 next cycle; rst asserted with sync_clr -> same all-zero state.
REQ-035 SHALL check (TICK_GEN_SCAN_EN, SCAN_W=2, div0=1): scan_idx sequence 0,1,2,3,0 advancing one cycle after each tick[0].
